// File: rtl/chunked_adder_if.sv
// chunked_adder handshake bundle.
// Operand side (in_*) and result side (out_*) share one interface.
interface chunked_adder_if #(
  parameter int WIDTH = 256
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
  );
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: WIDTH-bit add/sub, one CHUNK-bit slice per clock.
// Carry is registered between slices to keep the carry chain short.
module chunked_adder #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32
) (
  input logic           clk,
  input logic           rst,
  chunked_adder_if.slave bus
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CW =
    (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [WIDTH-1:0] LMASK =
    WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  int               w_off;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_add;
  logic [CHUNK-1:0] w_s;
  logic             w_c;
  logic             w_last;
  logic             w_accept;
  logic             w_release;

  // Slice selection and the per-cycle CHUNK-bit adder.
  assign w_off  = int'(r_cnt) * CHUNK;
  assign w_a_sl = CHUNK'(r_a >> w_off);
  assign w_b_sl = CHUNK'(r_b >> w_off);
  assign w_add  = {1'b0, w_a_sl}
                + {1'b0, w_b_sl}
                + (CHUNK + 1)'(r_carry);
  assign w_s    = w_add[CHUNK-1:0];
  assign w_c    = w_add[CHUNK];
  assign w_last =
    (r_cnt == CW'(NUM_CHUNKS - 1));

  assign w_accept  = (r_state == S_IDLE)
                   && bus.in_valid;
  assign w_release = (r_state == S_DONE)
                   && bus.out_ready;

  // State register; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: IDLE -> ADD -> DONE -> IDLE, no overlap.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_next = S_ADD;
        end
      end
      S_ADD: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decode directly from state.
  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.sum       = r_sum;
    bus.cout      = r_cout;
  end

  // Datapath: latch operands, then fold one slice per ADD cycle.
  // Subtraction is a + ~b + 1, so b is inverted at capture
  // and the carry register seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.sub ? ~bus.b : bus.b;
        r_carry <= bus.sub ? 1'b1 : bus.cin;
        r_cnt   <= '0;
      end
      if (r_state == S_ADD) begin
        r_sum   <= (r_sum & ~(LMASK << w_off))
                 | (WIDTH'(w_s) << w_off);
        r_carry <= w_c;
        if (w_last) begin
          r_cout <= w_c;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + CW'(1);
        end
      end
      if (w_release) begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: 64/16 and 1/1 configurations.
// Table-driven vectors plus backpressure and reset sequences.
module tb_chunked_adder;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(64)) bus64 ();
  chunked_adder_if #(.WIDTH(1))  bus1 ();

  chunked_adder #(.WIDTH(64), .CHUNK(16)) u64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  chunked_adder #(.WIDTH(1), .CHUNK(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] s;
    logic        co;
  } v64_t;

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic co;
  } v1_t;

  int checks = 0;
  int errors = 0;

  v64_t t64 [10];
  v1_t  t1  [4];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic run64(input v64_t v, input int idx);
    int lat;
    bit ir_bad;
    string nm;
    nm = $sformatf("v64[%0d]", idx);
    chk({nm, " in_ready before"}, 64'(bus64.in_ready), 64'd1);
    bus64.a        = v.a;
    bus64.b        = v.b;
    bus64.cin      = v.cin;
    bus64.sub      = v.sub;
    bus64.in_valid = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    lat = 0;
    ir_bad = 1'b0;
    while (!bus64.out_valid && lat < 50) begin
      if (bus64.in_ready) ir_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (bus64.in_ready) ir_bad = 1'b1;
    chk({nm, " latency"}, 64'(lat), 64'd4);
    chk({nm, " in_ready busy"}, 64'(ir_bad), 64'd0);
    chk({nm, " sum"}, bus64.sum, v.s);
    chk({nm, " cout"}, 64'(bus64.cout), 64'(v.co));
    @(posedge clk); #1;
    chk({nm, " out_valid drop"}, 64'(bus64.out_valid), 64'd0);
  endtask

  task automatic run1(input v1_t v, input int idx);
    int lat;
    string nm;
    nm = $sformatf("v1[%0d]", idx);
    bus1.a        = v.a;
    bus1.b        = v.b;
    bus1.cin      = 1'b0;
    bus1.sub      = 1'b0;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd1);
    chk({nm, " sum"}, 64'(bus1.sum), 64'(v.s));
    chk({nm, " cout"}, 64'(bus1.cout), 64'(v.co));
    @(posedge clk); #1;
    chk({nm, " in_ready"}, 64'(bus1.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [63:0] held;

    t64[0] = '{64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0};
    t64[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'd0, 1'b1};
    t64[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
               64'd0, 1'b1};
    t64[3] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1};
    t64[4] = '{64'd5, 64'd7, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    t64[5] = '{64'd9, 64'd0, 1'b0, 1'b1, 64'd9, 1'b1};
    t64[6] = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1};
    t64[7] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0};
    t64[8] = '{64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000, 1'b0, 1'b0,
               64'd0, 1'b1};
    t64[9] = '{64'h1234_5678_9ABC_DEF0,
               64'h1111_1111_1111_1111, 1'b1, 1'b0,
               64'h2345_6789_ABCD_F002, 1'b0};

    t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    t1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    t1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    bus64.in_valid  = 1'b0;
    bus64.a         = '0;
    bus64.b         = '0;
    bus64.cin       = 1'b0;
    bus64.sub       = 1'b0;
    bus64.out_ready = 1'b1;
    bus1.in_valid   = 1'b0;
    bus1.a          = '0;
    bus1.b          = '0;
    bus1.cin        = 1'b0;
    bus1.sub        = 1'b0;
    bus1.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst out_valid", 64'(bus64.out_valid), 64'd0);
    chk("rst in_ready", 64'(bus64.in_ready), 64'd1);
    chk("rst sum", bus64.sum, 64'd0);
    chk("rst cout", 64'(bus64.cout), 64'd0);
    chk("rst1 out_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst1 in_ready", 64'(bus1.in_ready), 64'd1);

    for (int i = 0; i < 10; i++) run64(t64[i], i);
    for (int i = 0; i < 4; i++) run1(t1[i], i);

    // Backpressure: result must hold, stray in_valid ignored.
    bus64.out_ready = 1'b0;
    bus64.a         = 64'd10;
    bus64.b         = 64'd20;
    bus64.cin       = 1'b0;
    bus64.sub       = 1'b0;
    bus64.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid  = 1'b0;
    lat = 0;
    while (!bus64.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 64'(lat), 64'd4);
    held = 64'd30;
    for (int i = 0; i < 5; i++) begin
      bus64.a        = 64'd99;
      bus64.b        = 64'd1;
      bus64.in_valid = 1'b1;
      chk("bp out_valid", 64'(bus64.out_valid), 64'd1);
      chk("bp sum", bus64.sum, held);
      chk("bp cout", 64'(bus64.cout), 64'd0);
      chk("bp in_ready", 64'(bus64.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus64.in_valid  = 1'b0;
    chk("bp still valid", 64'(bus64.out_valid), 64'd1);
    bus64.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", 64'(bus64.out_valid), 64'd0);
    chk("bp release ready", 64'(bus64.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp no stray accept", 64'(bus64.in_ready), 64'd1);

    // Reset while counter == 2.
    bus64.a        = 64'hFFFF_FFFF_FFFF_FFFF;
    bus64.b        = 64'd1;
    bus64.in_valid = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-op busy", 64'(bus64.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid rst out_valid", 64'(bus64.out_valid), 64'd0);
    chk("mid rst sum", bus64.sum, 64'd0);
    chk("mid rst cout", 64'(bus64.cout), 64'd0);
    chk("mid rst in_ready", 64'(bus64.in_ready), 64'd1);
    run64('{64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0}, 100);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
